mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 192 +++++++++++++++++++
 tb/tb_mc_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control unit: five-state FSM (IF/ID/EXE/MEM/WB) that
// sequences PC/IR/GPR/DM write enables and decodes datapath selects from ins.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic        ov,
    output logic        PCWr,
    output logic [1:0]  npc_sel,
    output logic        IRWr,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  regdst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  extop,
    output logic [1:0]  aluctr,
    output logic        alusrc,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_ov_q;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_rtype;
    logic       w_addu, w_subu, w_slt, w_jr;
    logic       w_j, w_jal, w_beq, w_addi, w_addiu, w_ori, w_lw, w_sw, w_lui;
    logic       w_is_alu;
    logic       w_legal;
    logic       w_unused_fields;

    logic       w_pcwr, w_irwr, w_regwrite, w_memwrite;
    logic [1:0] w_npc_sel;
    logic       w_sel_en;

    assign w_op     = ins[31:26];
    assign w_funct  = ins[5:0];
    assign w_rtype  = (w_op == 6'b000000);

    // Register fields only steer the datapath, never the control sequence.
    assign w_unused_fields = ^ins[25:6];

    assign w_addu  = w_rtype && (w_funct == 6'b100001);
    assign w_subu  = w_rtype && (w_funct == 6'b100011);
    assign w_slt   = w_rtype && (w_funct == 6'b101010);
    assign w_jr    = w_rtype && (w_funct == 6'b001000);
    assign w_j     = (w_op == 6'b000010);
    assign w_jal   = (w_op == 6'b000011);
    assign w_beq   = (w_op == 6'b000100);
    assign w_addi  = (w_op == 6'b001000);
    assign w_addiu = (w_op == 6'b001001);
    assign w_ori   = (w_op == 6'b001101);
    assign w_lw    = (w_op == 6'b100011);
    assign w_sw    = (w_op == 6'b101011);
    assign w_lui   = (w_op == 6'b001111);

    assign w_is_alu = w_addu | w_subu | w_slt | w_ori | w_addi | w_addiu | w_lui;
    assign w_legal  = w_is_alu | w_jr | w_j | w_jal | w_beq | w_lw | w_sw;

    // ov_q is refreshed on every EXE so a stale overflow never suppresses a later lw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_ov_q  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXE) begin
                r_ov_q <= ov & w_addi;
            end
        end
    end

    always_comb begin
        w_next     = S_IF;
        w_pcwr     = 1'b0;
        w_irwr     = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_npc_sel  = 2'b00;
        w_sel_en   = 1'b0;
        case (r_state)
            S_IF: begin
                w_irwr = 1'b1;
                w_pcwr = 1'b1;
                w_next = S_ID;
            end
            S_ID: begin
                w_sel_en = 1'b1;
                if (w_j) begin
                    w_pcwr    = 1'b1;
                    w_npc_sel = 2'b10;
                end else if (w_jal) begin
                    w_pcwr     = 1'b1;
                    w_npc_sel  = 2'b10;
                    w_regwrite = 1'b1;
                end else if (w_jr) begin
                    w_pcwr    = 1'b1;
                    w_npc_sel = 2'b11;
                end else if (w_legal) begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                w_sel_en = 1'b1;
                if (w_beq) begin
                    w_pcwr    = zero;
                    w_npc_sel = 2'b01;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_is_alu) begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_sel_en = 1'b1;
                if (w_sw) begin
                    w_memwrite = 1'b1;
                end else if (w_lw) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_sel_en   = 1'b1;
                w_regwrite = ~r_ov_q;
            end
            default: w_next = S_IF;
        endcase
    end

    always_comb begin
        regdst   = 2'b00;
        MemtoReg = 2'b00;
        extop    = 2'b00;
        aluctr   = 2'b00;
        alusrc   = 1'b0;
        if (w_sel_en) begin
            if (w_addu) begin
                regdst = 2'b01;
            end else if (w_subu) begin
                regdst = 2'b01;
                aluctr = 2'b01;
            end else if (w_slt) begin
                regdst   = 2'b01;
                MemtoReg = 2'b11;
                aluctr   = 2'b01;
            end else if (w_jal) begin
                regdst   = 2'b10;
                MemtoReg = 2'b10;
            end else if (w_beq) begin
                aluctr = 2'b01;
            end else if (w_addi) begin
                extop  = 2'b01;
                aluctr = 2'b11;
                alusrc = 1'b1;
            end else if (w_addiu || w_sw) begin
                extop  = 2'b01;
                alusrc = 1'b1;
            end else if (w_ori) begin
                aluctr = 2'b10;
                alusrc = 1'b1;
            end else if (w_lw) begin
                MemtoReg = 2'b01;
                extop    = 2'b01;
                alusrc   = 1'b1;
            end else if (w_lui) begin
                extop  = 2'b10;
                aluctr = 2'b10;
                alusrc = 1'b1;
            end
        end
    end

    // Enables are gated by reset itself so they drop the instant reset rises.
    assign PCWr     = w_pcwr & ~reset;
    assign IRWr     = w_irwr & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign npc_sel  = w_npc_sel;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle vector table for mc_controller plus hand-written
// reset sequences.
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] ins;
    logic        zero;
    logic        ov;
    logic        PCWr;
    logic [1:0]  npc_sel;
    logic        IRWr;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  regdst;
    logic [1:0]  MemtoReg;
    logic [1:0]  extop;
    logic [1:0]  aluctr;
    logic        alusrc;
    logic [2:0]  state;

    int n_vectors = 0;
    int n_miscompares = 0;

    mc_controller dut (
        .clk      (clk),
        .reset    (reset),
        .ins      (ins),
        .zero     (zero),
        .ov       (ov),
        .PCWr     (PCWr),
        .npc_sel  (npc_sel),
        .IRWr     (IRWr),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .regdst   (regdst),
        .MemtoReg (MemtoReg),
        .extop    (extop),
        .aluctr   (aluctr),
        .alusrc   (alusrc),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ins;
        logic        zero;
        logic        ov;
        logic [2:0]  st;
        logic [3:0]  en;       // {PCWr, IRWr, RegWrite, MemWrite}
        logic [1:0]  npc;
        logic        npc_chk;
        logic [8:0]  sel;      // {regdst, MemtoReg, extop, aluctr, alusrc}
        logic [8:0]  mask;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_LW   = 32'h8C430004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_ADDI = 32'h20420001;
    localparam logic [31:0] I_J    = 32'h08000000;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_SW   = 32'hAC430000;
    localparam logic [31:0] I_ADDU = 32'h00430821;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    localparam logic [8:0] S_LW   = 9'b00_01_01_00_1;
    localparam logic [8:0] S_SW   = 9'b00_00_01_00_1;
    localparam logic [8:0] M_SW   = 9'b00_00_11_11_1;
    localparam logic [8:0] S_BEQ  = 9'b00_00_00_01_0;
    localparam logic [8:0] M_BEQ  = 9'b00_00_00_11_1;
    localparam logic [8:0] S_JAL  = 9'b10_10_00_00_0;
    localparam logic [8:0] M_JAL  = 9'b11_11_00_00_0;
    localparam logic [8:0] S_ADDI = 9'b00_00_01_11_1;
    localparam logic [8:0] S_ADDU = 9'b01_00_00_00_0;
    localparam logic [8:0] M_ADDU = 9'b11_11_00_11_1;
    localparam logic [8:0] M_ALL  = 9'h1FF;

    task automatic push(input logic [31:0] i, input logic z, input logic o,
                        input logic [2:0] s, input logic [3:0] e,
                        input logic [1:0] n, input logic nc,
                        input logic [8:0] sl, input logic [8:0] mk);
        vec_t v;
        v.ins = i; v.zero = z; v.ov = o; v.st = s; v.en = e;
        v.npc = n; v.npc_chk = nc; v.sel = sl; v.mask = mk;
        vecs.push_back(v);
    endtask

    task automatic push_if(input logic [31:0] i);
        push(i, 1'b0, 1'b0, 3'd0, 4'b1100, 2'b00, 1'b1, 9'd0, 9'd0);
    endtask

    task automatic push_lw();
        push_if(I_LW);
        push(I_LW, 0, 0, 3'd1, 4'b0000, 2'b00, 0, S_LW, M_ALL);
        push(I_LW, 0, 0, 3'd2, 4'b0000, 2'b00, 0, S_LW, M_ALL);
        push(I_LW, 0, 0, 3'd3, 4'b0000, 2'b00, 0, S_LW, M_ALL);
        push(I_LW, 0, 0, 3'd4, 4'b0010, 2'b00, 0, S_LW, M_ALL);
    endtask

    task automatic push_addi(input logic o);
        push_if(I_ADDI);
        push(I_ADDI, 0, 0, 3'd1, 4'b0000, 2'b00, 0, S_ADDI, M_ALL);
        push(I_ADDI, 0, o, 3'd2, 4'b0000, 2'b00, 0, S_ADDI, M_ALL);
        push(I_ADDI, 0, 0, 3'd4, o ? 4'b0000 : 4'b0010, 2'b00, 0, S_ADDI, M_ALL);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] sel_now();
        return {regdst, MemtoReg, extop, aluctr, alusrc};
    endfunction

    initial begin
        // lw, beq taken/not taken, jal, addi with/without overflow around a lw
        push_lw();
        push_if(I_BEQ);
        push(I_BEQ, 1, 0, 3'd1, 4'b0000, 2'b00, 0, S_BEQ, M_BEQ);
        push(I_BEQ, 1, 0, 3'd2, 4'b1000, 2'b01, 1, S_BEQ, M_BEQ);
        push_if(I_BEQ);
        push(I_BEQ, 0, 0, 3'd1, 4'b0000, 2'b00, 0, S_BEQ, M_BEQ);
        push(I_BEQ, 0, 0, 3'd2, 4'b0000, 2'b01, 1, S_BEQ, M_BEQ);
        push_if(I_JAL);
        push(I_JAL, 0, 0, 3'd1, 4'b1010, 2'b10, 1, S_JAL, M_JAL);
        push_addi(1'b1);
        push_lw();
        push_addi(1'b0);
        push_if(I_J);
        push(I_J, 0, 0, 3'd1, 4'b1000, 2'b10, 1, 9'd0, 9'd0);
        push_if(I_JR);
        push(I_JR, 0, 0, 3'd1, 4'b1000, 2'b11, 1, 9'd0, 9'd0);
        push_if(I_SW);
        push(I_SW, 0, 0, 3'd1, 4'b0000, 2'b00, 0, S_SW, M_SW);
        push(I_SW, 0, 0, 3'd2, 4'b0000, 2'b00, 0, S_SW, M_SW);
        push(I_SW, 0, 0, 3'd3, 4'b0001, 2'b00, 0, S_SW, M_SW);
        push_if(I_ADDU);
        push(I_ADDU, 0, 0, 3'd1, 4'b0000, 2'b00, 0, S_ADDU, M_ADDU);
        push(I_ADDU, 0, 0, 3'd2, 4'b0000, 2'b00, 0, S_ADDU, M_ADDU);
        push(I_ADDU, 0, 0, 3'd4, 4'b0010, 2'b00, 0, S_ADDU, M_ADDU);
        push_if(I_ILL);
        push(I_ILL, 0, 0, 3'd1, 4'b0000, 2'b00, 0, 9'd0, 9'd0);
        push_if(I_ILL);

        // Reset state: IF, with all enables forced low while reset is high.
        reset = 1'b1;
        ins   = I_LW;
        zero  = 1'b0;
        ov    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vectors++;
        check("reset state", {29'd0, state}, 32'd0);
        check("reset enables", {28'd0, PCWr, IRWr, RegWrite, MemWrite}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            ins  = vecs[k].ins;
            zero = vecs[k].zero;
            ov   = vecs[k].ov;
            @(negedge clk);
            n_vectors++;
            check($sformatf("v%0d state", k), {29'd0, state}, {29'd0, vecs[k].st});
            check($sformatf("v%0d enables", k), {28'd0, PCWr, IRWr, RegWrite, MemWrite},
                  {28'd0, vecs[k].en});
            if (vecs[k].npc_chk)
                check($sformatf("v%0d npc_sel", k), {30'd0, npc_sel}, {30'd0, vecs[k].npc});
            check($sformatf("v%0d selects", k), {23'd0, sel_now() & vecs[k].mask},
                  {23'd0, vecs[k].sel & vecs[k].mask});
            @(posedge clk);
            #1;
        end

        // sw with reset pulsed during MEM: MemWrite must drop at once.
        reset = 1'b1;
        ins   = I_SW;
        zero  = 1'b0;
        ov    = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_vectors++;
        check("sw MEM state", {29'd0, state}, 32'd3);
        check("sw MEM MemWrite", {31'd0, MemWrite}, 32'd1);
        #2 reset = 1'b1;
        #1;
        n_vectors++;
        check("rst MemWrite", {31'd0, MemWrite}, 32'd0);
        check("rst state", {29'd0, state}, 32'd0);
        check("rst IF enables", {30'd0, PCWr, IRWr}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_vectors++;
        check("post-rst state", {29'd0, state}, 32'd0);
        check("post-rst IRWr", {31'd0, IRWr}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        n_vectors++;
        check("post-rst ID", {29'd0, state}, 32'd1);
        check("post-rst no MemWrite", {31'd0, MemWrite}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
